// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Iterative RV32M-style multiply/divide execute unit. It sits beside the
// single-cycle ALU, takes one M-extension op at a time, stalls the pipeline
// while it iterates (one bit per cycle), and then presents a registered
// one-cycle writeback result to the MEM stage.
//
// Parameters:
//   XLEN   datapath width (even, >= 8)
//   CNT_W  iteration counter width (2**CNT_W > XLEN)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes all state
//   flush_i         abandon the current op (has priority over valid_i)
//   valid_i         op presented this cycle
//   op_i            funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   reg1_i, reg2_i  rs1 / rs2 operands
//   wd_i            destination register address
//   stall_req_o     hold the upstream pipeline
//   busy_o          unit is not idle
//   valid_o         one-cycle result pulse
//   wd_o, wreg_o    destination address and write enable
//   wdata_o         result data
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        wd_q, wd_d;
    logic              negRes_q, negRes_d;
    logic              negRem_q, negRem_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [XLEN:0]     hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              outValid_q, outValid_d;
    logic              outWreg_q, outWreg_d;
    logic [4:0]        outWd_q, outWd_d;
    logic [XLEN-1:0]   outData_q, outData_d;

    logic              rs1Neg, rs2Neg;
    logic [XLEN-1:0]   absA, absB;
    logic              divByZero, divOverflow, special;
    logic [XLEN-1:0]   specialResult;
    logic              accept;

    logic [XLEN-1:0]   mulAddend;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divShift, divDiff;
    logic [XLEN:0]     stepHi;
    logic [XLEN-1:0]   stepLo;
    logic [2*XLEN-1:0] product, productS;
    logic [XLEN-1:0]   quotient, remainder;
    logic [XLEN-1:0]   calcResult;

    // Decode the incoming op: which operands are treated as signed, their
    // magnitudes, and whether this is a divide corner case that can be
    // answered immediately without iterating. Divide-by-zero returns the raw
    // rs1 as remainder, so it deliberately uses reg1_i rather than absA.
    always_comb begin
        rs1Neg      = 1'b0;
        rs2Neg      = 1'b0;
        case (op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                rs1Neg = reg1_i[XLEN-1];
                rs2Neg = reg2_i[XLEN-1];
            end
            OP_MULHSU: rs1Neg = reg1_i[XLEN-1];
            default: ;
        endcase
        absA        = rs1Neg ? -reg1_i : reg1_i;
        absB        = rs2Neg ? -reg2_i : reg2_i;
        divByZero   = op_i[2] && (reg2_i == '0);
        divOverflow = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (reg1_i == MIN_NEG) && (reg2_i == '1);
        special     = divByZero || divOverflow;
        if (op_i[1])
            specialResult = divByZero ? reg1_i : '0;
        else
            specialResult = divByZero ? '1 : reg1_i;
        accept      = valid_i && !flush_i;
    end

    // One iteration of the datapath. The hi/lo pair is shared: for multiply
    // lo holds the remaining multiplier bits and hi the running high half
    // (shift-add, shifting right); for divide lo holds the dividend bits
    // being shifted in and collects quotient bits, while hi is the
    // (XLEN+1)-bit partial remainder of the restoring divider. The final
    // signed result is formed from the step outputs so it can be registered
    // on the same edge that leaves CALC.
    always_comb begin
        mulAddend = lo_q[0] ? operand_q : '0;
        mulSum    = hi_q + {1'b0, mulAddend};
        divShift  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        divDiff   = divShift - {1'b0, operand_q};
        if (op_q[2]) begin
            stepHi = divDiff[XLEN] ? divShift : divDiff;
            stepLo = {lo_q[XLEN-2:0], ~divDiff[XLEN]};
        end else begin
            stepHi = {1'b0, mulSum[XLEN:1]};
            stepLo = {mulSum[0], lo_q[XLEN-1:1]};
        end
        product   = {stepHi[XLEN-1:0], stepLo};
        productS  = negRes_q ? -product : product;
        quotient  = negRes_q ? -stepLo : stepLo;
        remainder = negRem_q ? -stepHi[XLEN-1:0] : stepHi[XLEN-1:0];
        if (op_q[2])
            calcResult = op_q[1] ? remainder : quotient;
        else
            calcResult = (op_q[1:0] == 2'b00) ? productS[XLEN-1:0]
                                              : productS[2*XLEN-1:XLEN];
    end

    // Next-state and next-output logic. Result registers default to zero so
    // they only carry data during the single DONE cycle. A new op may be
    // accepted from DONE as well as IDLE, which gives back-to-back issue.
    // Flush is applied last so it overrides everything else.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        wd_d       = wd_q;
        negRes_d   = negRes_q;
        negRem_d   = negRem_q;
        operand_d  = operand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        outValid_d = 1'b0;
        outWreg_d  = 1'b0;
        outWd_d    = '0;
        outData_d  = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d      = op_i;
                    wd_d      = wd_i;
                    negRes_d  = rs1Neg ^ rs2Neg;
                    negRem_d  = rs1Neg;
                    cnt_d     = '0;
                    hi_d      = '0;
                    operand_d = op_i[2] ? absB : absA;
                    lo_d      = op_i[2] ? absA : absB;
                    if (special) begin
                        state_d    = DONE;
                        outValid_d = 1'b1;
                        outWreg_d  = (wd_i != 5'd0);
                        outWd_d    = wd_i;
                        outData_d  = (wd_i != 5'd0) ? specialResult : '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = stepHi;
                lo_d  = stepLo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    outValid_d = 1'b1;
                    outWreg_d  = (wd_q != 5'd0);
                    outWd_d    = wd_q;
                    outData_d  = (wd_q != 5'd0) ? calcResult : '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            outValid_d = 1'b0;
            outWreg_d  = 1'b0;
            outWd_d    = '0;
            outData_d  = '0;
        end
    end

    // State register. Reset wins over everything; with rdy low nothing moves,
    // so the counter pauses and the outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            wd_q       <= '0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            operand_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            outValid_q <= 1'b0;
            outWreg_q  <= 1'b0;
            outWd_q    <= '0;
            outData_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            wd_q       <= wd_d;
            negRes_q   <= negRes_d;
            negRem_q   <= negRem_d;
            operand_q  <= operand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            outValid_q <= outValid_d;
            outWreg_q  <= outWreg_d;
            outWd_q    <= outWd_d;
            outData_q  <= outData_d;
        end
    end

    // Stall is low in DONE so the pipeline advances while valid_o is high.
    assign stall_req_o = ((state_q == IDLE) && valid_i && !flush_i) ||
                         (state_q == CALC);
    assign busy_o      = (state_q != IDLE);
    assign valid_o     = outValid_q;
    assign wreg_o      = outWreg_q;
    assign wd_o        = outWd_q;
    assign wdata_o     = outData_q;

endmodule
